// File: rtl/adder_prefix_pipe_pkg.sv
// Shared definitions for the pipelined prefix adder: lane-mode encodings,
// lane geometry helpers and the generate/propagate combine cell.
package adder_prefix_pipe_pkg;

   localparam int unsigned SLICE_W     = 8;
   localparam int unsigned LANE_MODE_W = 2;

   typedef enum logic [LANE_MODE_W-1:0] {
      LANE_MODE_8  = 2'd0,
      LANE_MODE_16 = 2'd1,
      LANE_MODE_32 = 2'd2,
      LANE_MODE_64 = 2'd3
   } lane_mode_e;

   // Lane size in bits, clamped to the datapath width.
   function automatic int unsigned lane_size(input logic [LANE_MODE_W-1:0] mode,
                                             input int unsigned width);
      int unsigned ls;
      ls = 32'd8;
      case (lane_mode_e'(mode))
         LANE_MODE_8:  ls = 32'd8;
         LANE_MODE_16: ls = 32'd16;
         LANE_MODE_32: ls = 32'd32;
         LANE_MODE_64: ls = 32'd64;
         default:      ls = 32'd8;
      endcase
      return (ls > width) ? width : ls;
   endfunction

   // Prefix level k only combines inside a lane: its 2^k block must fit in the lane.
   function automatic logic level_enable(input logic [LANE_MODE_W-1:0] mode,
                                         input int unsigned k,
                                         input int unsigned width);
      return (32'd1 << k) <= lane_size(mode, width);
   endfunction

   // True when 8-bit slice 'slice' holds the MSB of its lane.
   function automatic logic lane_msb_slice(input logic [LANE_MODE_W-1:0] mode,
                                           input int unsigned slice,
                                           input int unsigned width);
      return (((slice + 32'd1) * SLICE_W) % lane_size(mode, width)) == 32'd0;
   endfunction

   // Combine a higher (g,p) group with the adjacent lower group; returns {g, p}.
   function automatic logic [1:0] gp_cell(input logic g_hi, input logic p_hi,
                                          input logic g_lo, input logic p_lo);
      return {g_hi | (p_hi & g_lo), p_hi & p_lo};
   endfunction

endpackage

// File: rtl/adder_prefix_pipe_if.sv
// Operand/result bus of the prefix adder.
//   master: issues operands (in_valid, op_a, op_b, op_sub, lane_mode, cin) and
//           accepts results (out_ready); sees in_ready, out_valid, sum, cout, ovf.
//   slave : the adder side of the same bus.
interface adder_prefix_pipe_if #(
   parameter int unsigned WIDTH = 64
) ();
   localparam int unsigned NSLICE = WIDTH / 8;

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  op_a;
   logic [WIDTH-1:0]  op_b;
   logic              op_sub;
   logic [1:0]        lane_mode;
   logic [NSLICE-1:0] cin;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  sum;
   logic [NSLICE-1:0] cout;
   logic [NSLICE-1:0] ovf;

   modport master (
      output in_valid, op_a, op_b, op_sub, lane_mode, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, op_a, op_b, op_sub, lane_mode, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/adder_prefix_pipe_level.sv
// One Sklansky prefix level (index K, span 2^(K-1)), purely combinational.
//   g_i, p_i   : group generate/propagate entering the level
//   lane_mode  : lane partitioning of this beat; disables the level when a
//                2^K block would straddle a lane boundary
//   g_o, p_o   : group generate/propagate leaving the level
module adder_prefix_pipe_level
   import adder_prefix_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned K     = 1
) (
   input  logic [WIDTH-1:0]       g_i,
   input  logic [WIDTH-1:0]       p_i,
   input  logic [LANE_MODE_W-1:0] lane_mode,
   output logic [WIDTH-1:0]       g_o,
   output logic [WIDTH-1:0]       p_o
);
   localparam int unsigned SPAN = 32'd1 << (K - 32'd1);

   logic       en_c;
   logic [1:0] gp_c;
   int         src_c;

   assign en_c = level_enable(lane_mode, K, WIDTH);

   // Upper half of each 2^K block absorbs the top bit of the lower half.
   always_comb begin
      g_o   = g_i;
      p_o   = p_i;
      gp_c  = 2'b00;
      src_c = 0;
      if (en_c) begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((i % (2 * SPAN)) >= SPAN) begin
               src_c  = (i | (SPAN - 1)) - SPAN;
               gp_c   = gp_cell(g_i[i], p_i[i], g_i[src_c], p_i[src_c]);
               g_o[i] = gp_c[1];
               p_o[i] = gp_c[0];
            end
         end
      end
   end
endmodule

// File: rtl/adder_prefix_pipe.sv
// Pipelined Sklansky adder/subtractor with 1x64 / 2x32 / 4x16 / 8x8 SIMD lanes.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of adder_prefix_pipe_if (elastic valid/ready in and out)
// PIPE_MASK bit k places a register after prefix level k+1; the output
// register is always present, so latency is 1 + popcount(PIPE_MASK).
module adder_prefix_pipe
   import adder_prefix_pipe_pkg::*;
#(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned LEVELS    = 6,
   parameter int unsigned PIPE_MASK = 32'h0000_0004
) (
   input  logic               clk,
   input  logic               rst_n,
   adder_prefix_pipe_if.slave bus
);
   localparam int unsigned NSLICE = WIDTH / SLICE_W;

   if (WIDTH < 32'd8 || (32'd1 << LEVELS) != WIDTH) begin : g_bad_width
      $error("adder_prefix_pipe: WIDTH must equal 2**LEVELS and be at least 8");
   end
   if ((PIPE_MASK >> LEVELS) != 32'd0) begin : g_bad_mask
      $error("adder_prefix_pipe: PIPE_MASK has bits beyond LEVELS");
   end

   logic out_acc;

   // Level j: combinational output (_c), then an optional register (_q).
   for (genvar j = 0; j <= LEVELS; j++) begin : g_lv
      localparam bit HAS_REG = (j != 0) && ((((PIPE_MASK << 1) >> j) & 32'd1) != 32'd0);

      logic [WIDTH-1:0]       g_c, p_c, p0_c;
      logic [LANE_MODE_W-1:0] m_c;
      logic [NSLICE-1:0]      lc_c;
      logic                   v_c;
      logic [WIDTH-1:0]       g_q, p_q, p0_q;
      logic [LANE_MODE_W-1:0] m_q;
      logic [NSLICE-1:0]      lc_q;
      logic                   v_q;
      logic                   rdy_in, rdy_out;

      if (j == 0) begin : g_l0
         // Subtraction: invert B and force every lane carry-in to 1.
         logic [WIDTH-1:0] b_eff;
         assign b_eff = bus.op_b ^ {WIDTH{bus.op_sub}};
         assign g_c   = bus.op_a & b_eff;
         assign p_c   = bus.op_a ^ b_eff;
         assign p0_c  = bus.op_a ^ b_eff;
         assign m_c   = bus.lane_mode;
         assign lc_c  = bus.cin | {NSLICE{bus.op_sub}};
         assign v_c   = bus.in_valid;
      end else begin : g_ln
         adder_prefix_pipe_level #(
            .WIDTH (WIDTH),
            .K     (j)
         ) u_level (
            .g_i       (g_lv[j-1].g_q),
            .p_i       (g_lv[j-1].p_q),
            .lane_mode (g_lv[j-1].m_q),
            .g_o       (g_c),
            .p_o       (p_c)
         );
         assign p0_c = g_lv[j-1].p0_q;
         assign m_c  = g_lv[j-1].m_q;
         assign lc_c = g_lv[j-1].lc_q;
         assign v_c  = g_lv[j-1].v_q;
      end

      if (HAS_REG) begin : g_reg
         logic [WIDTH-1:0]       g_r, p_r, p0_r;
         logic [LANE_MODE_W-1:0] m_r;
         logic [NSLICE-1:0]      lc_r;
         logic                   v_r;

         // Stage accepts when empty or when its downstream takes the held beat.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_r  <= 1'b0;
               g_r  <= '0;
               p_r  <= '0;
               p0_r <= '0;
               m_r  <= '0;
               lc_r <= '0;
            end else if (rdy_in) begin
               v_r <= v_c;
               if (v_c) begin
                  g_r  <= g_c;
                  p_r  <= p_c;
                  p0_r <= p0_c;
                  m_r  <= m_c;
                  lc_r <= lc_c;
               end
            end
         end

         assign g_q    = g_r;
         assign p_q    = p_r;
         assign p0_q   = p0_r;
         assign m_q    = m_r;
         assign lc_q   = lc_r;
         assign v_q    = v_r;
         assign rdy_in = !v_r || rdy_out;
      end else begin : g_wire
         assign g_q    = g_c;
         assign p_q    = p_c;
         assign p0_q   = p0_c;
         assign m_q    = m_c;
         assign lc_q   = lc_c;
         assign v_q    = v_c;
         assign rdy_in = rdy_out;
      end

      if (j == LEVELS) begin : g_tail
         assign rdy_out = out_acc;
      end else begin : g_mid
         assign rdy_out = g_lv[j+1].rdy_in;
      end
   end

   logic [WIDTH-1:0]       fin_g, fin_p, fin_p0;
   logic [LANE_MODE_W-1:0] fin_m;
   logic [NSLICE-1:0]      fin_lc;
   logic                   fin_v;

   assign fin_g  = g_lv[LEVELS].g_q;
   assign fin_p  = g_lv[LEVELS].p_q;
   assign fin_p0 = g_lv[LEVELS].p0_q;
   assign fin_m  = g_lv[LEVELS].m_q;
   assign fin_lc = g_lv[LEVELS].lc_q;
   assign fin_v  = g_lv[LEVELS].v_q;

   assign bus.in_ready = g_lv[0].rdy_in;

   logic [WIDTH-1:0]  carry_c, sum_c;
   logic [NSLICE-1:0] cout_c, ovf_c;
   int unsigned       lsz_c, base_c, msb_c;
   logic              lcin_c, co_c;

   // Carries from lane-local prefixes; the lane carry-in comes from its LSB slice.
   always_comb begin
      carry_c = '0;
      sum_c   = '0;
      cout_c  = '0;
      ovf_c   = '0;
      base_c  = 32'd0;
      msb_c   = 32'd0;
      lcin_c  = 1'b0;
      co_c    = 1'b0;
      lsz_c   = lane_size(fin_m, WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         base_c = i - (i % lsz_c);
         lcin_c = fin_lc[base_c / SLICE_W];
         if (i == base_c) begin
            carry_c[i] = lcin_c;
         end else begin
            carry_c[i] = fin_g[i-1] | (fin_p[i-1] & lcin_c);
         end
         sum_c[i] = fin_p0[i] ^ carry_c[i];
      end
      for (int s = 0; s < NSLICE; s++) begin
         if (lane_msb_slice(fin_m, s, WIDTH)) begin
            msb_c     = s * SLICE_W + (SLICE_W - 1);
            base_c    = msb_c + 1 - lsz_c;
            lcin_c    = fin_lc[base_c / SLICE_W];
            co_c      = fin_g[msb_c] | (fin_p[msb_c] & lcin_c);
            cout_c[s] = co_c;
            ovf_c[s]  = carry_c[msb_c] ^ co_c;
         end
      end
   end

   logic              out_valid_q;
   logic [WIDTH-1:0]  sum_q;
   logic [NSLICE-1:0] cout_q, ovf_q;

   assign out_acc = !out_valid_q || bus.out_ready;

   // Output register; holds its beat while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= '0;
         ovf_q       <= '0;
      end else if (out_acc) begin
         out_valid_q <= fin_v;
         if (fin_v) begin
            sum_q  <= sum_c;
            cout_q <= cout_c;
            ovf_q  <= ovf_c;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adder_prefix_pipe.sv
// Bench for adder_prefix_pipe: three instances (PIPE_MASK 0, 6'b000100,
// 6'b111111) share single-beat vectors; the default instance also runs a
// stalled random stream and a mid-flight reset.
module tb_adder_prefix_pipe;
   localparam int unsigned W = 64;

   typedef struct packed {
      logic [63:0] s;
      logic [7:0]  c;
      logic [7:0]  o;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;
   logic sweep_en;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   adder_prefix_pipe_if #(.WIDTH(W)) bus0 ();
   adder_prefix_pipe_if #(.WIDTH(W)) bus4 ();
   adder_prefix_pipe_if #(.WIDTH(W)) bus63 ();

   adder_prefix_pipe #(.WIDTH(W), .LEVELS(6), .PIPE_MASK(32'h00)) u_dut_m0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   adder_prefix_pipe #(.WIDTH(W), .LEVELS(6), .PIPE_MASK(32'h04)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus4));
   adder_prefix_pipe #(.WIDTH(W), .LEVELS(6), .PIPE_MASK(32'h3F)) u_dut_m63 (
      .clk(clk), .rst_n(rst_n), .bus(bus63));

   assign bus0.in_valid   = bus4.in_valid & sweep_en;
   assign bus0.op_a       = bus4.op_a;
   assign bus0.op_b       = bus4.op_b;
   assign bus0.op_sub     = bus4.op_sub;
   assign bus0.lane_mode  = bus4.lane_mode;
   assign bus0.cin        = bus4.cin;
   assign bus0.out_ready  = bus4.out_ready;
   assign bus63.in_valid  = bus4.in_valid & sweep_en;
   assign bus63.op_a      = bus4.op_a;
   assign bus63.op_b      = bus4.op_b;
   assign bus63.op_sub    = bus4.op_sub;
   assign bus63.lane_mode = bus4.lane_mode;
   assign bus63.cin       = bus4.cin;
   assign bus63.out_ready = bus4.out_ready;

   // Lane-wise arithmetic reference: each lane is an independent lsz-bit add.
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                  input logic [1:0] mode, input logic [7:0] ci);
      res_t        r;
      int unsigned lsz, nl;
      logic [64:0] ml, al, bl, t;
      logic        c_l;
      r   = '0;
      lsz = 32'd8 << mode;
      nl  = 64 / lsz;
      ml  = (65'd1 << lsz) - 65'd1;
      for (int l = 0; l < nl; l++) begin
         al = (65'(a) >> (l * lsz)) & ml;
         bl = (65'(b) >> (l * lsz)) & ml;
         if (sub) bl = ~bl & ml;
         c_l = sub ? 1'b1 : ci[l * lsz / 8];
         t = al + bl + 65'(c_l);
         r.s = r.s | 64'((t & ml) << (l * lsz));
         r.c[(l + 1) * lsz / 8 - 1] = t[lsz];
         r.o[(l + 1) * lsz / 8 - 1] = (al[lsz-1] == bl[lsz-1]) && (t[lsz-1] != al[lsz-1]);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input int n);
      bus4.op_a      = {$urandom, $urandom};
      bus4.op_b      = {$urandom, $urandom};
      bus4.op_sub    = 1'($urandom_range(0, 1));
      bus4.lane_mode = 2'(n % 4);
      bus4.cin       = 8'($urandom);
      bus4.in_valid  = 1'b1;
   endtask

   // One beat through all three instances; checks result and latency of each.
   task automatic send_single(input logic [63:0] a, input logic [63:0] b, input logic sub,
                              input logic [1:0] mode, input logic [7:0] ci, input string tag,
                              output res_t r4);
      res_t e;
      res_t res[3];
      int   lat[3];
      int   exp_lat[3];
      e = model(a, b, sub, mode, ci);
      exp_lat = '{1 + $countones(6'b000000), 1 + $countones(6'b000100), 1 + $countones(6'b111111)};
      lat = '{0, 0, 0};
      res = '{'0, '0, '0};
      bus4.op_a = a; bus4.op_b = b; bus4.op_sub = sub; bus4.lane_mode = mode; bus4.cin = ci;
      bus4.out_ready = 1'b1;
      bus4.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (lat[0] == 0 && bus0.out_valid)  begin lat[0] = cyc; res[0] = {bus0.sum, bus0.cout, bus0.ovf}; end
         if (lat[1] == 0 && bus4.out_valid)  begin lat[1] = cyc; res[1] = {bus4.sum, bus4.cout, bus4.ovf}; end
         if (lat[2] == 0 && bus63.out_valid) begin lat[2] = cyc; res[2] = {bus63.sum, bus63.cout, bus63.ovf}; end
         @(posedge clk); #1;
      end
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_lat_d%0d", tag, d), 64'(lat[d]), 64'(exp_lat[d]));
         chk($sformatf("%s_sum_d%0d", tag, d), res[d].s, e.s);
         chk($sformatf("%s_cout_d%0d", tag, d), 64'(res[d].c), 64'(e.c));
         chk($sformatf("%s_ovf_d%0d", tag, d), 64'(res[d].o), 64'(e.o));
      end
      r4 = res[1];
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   res_t        r, held, e;
   res_t        q[$];
   int          sent, got, seen;
   logic        acc, stall_prev;

   initial begin
      rst_n = 1'b0;
      sweep_en = 1'b1;
      bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.op_sub = 1'b0;
      bus4.lane_mode = 2'd0; bus4.cin = '0; bus4.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
      chk("rst_sum", bus4.sum, 64'd0);
      chk("rst_cout_ovf", 64'({bus4.cout, bus4.ovf}), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(bus4.in_ready), 64'd1);

      // Directed vectors with their known answers
      send_single(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'd3, 8'h00, "t1", r);
      chk("t1_sum_lit", r.s, 64'd0);
      chk("t1_cout_lit", 64'(r.c), 64'h80);
      chk("t1_ovf_lit", 64'(r.o), 64'h00);
      send_single(64'h7F7F_7F7F_7F7F_7F7F, 64'h0101_0101_0101_0101, 1'b0, 2'd0, 8'h00, "t2", r);
      chk("t2_sum_lit", r.s, 64'h8080_8080_8080_8080);
      chk("t2_ovf_lit", 64'(r.o), 64'hFF);
      chk("t2_cout_lit", 64'(r.c), 64'h00);
      send_single(64'h0000_0005_0003_0010, 64'h0001_0005_0004_0001, 1'b1, 2'd1, 8'h00, "t3", r);
      chk("t3_sum_lit", r.s, 64'hFFFF_0000_FFFF_000F);
      chk("t3_cout_lit", 64'(r.c), 64'h22);

      // Random single beats across all pipe masks and modes
      for (int n = 0; n < 8; n++) begin
         send_single({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     2'(n % 4), 8'($urandom), $sformatf("rnd%0d", n), r);
      end

      // Random stream with out_ready toggling 1010..
      sweep_en = 1'b0;
      q.delete();
      sent = 0; got = 0; stall_prev = 1'b0; held = '0;
      present(0);
      for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
         bus4.out_ready = (cyc % 2 == 0);
         @(negedge clk);
         if (stall_prev) begin
            chk("stall_valid", 64'(bus4.out_valid), 64'd1);
            chk("stall_sum", bus4.sum, held.s);
            chk("stall_flags", 64'({bus4.cout, bus4.ovf}), 64'({held.c, held.o}));
         end
         if (bus4.out_ready) chk("full_rate_in_ready", 64'(bus4.in_ready), 64'd1);
         if (bus4.out_valid && bus4.out_ready) begin
            chk("stream_has_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk($sformatf("stream_sum_%0d", got), bus4.sum, e.s);
               chk($sformatf("stream_flags_%0d", got), 64'({bus4.cout, bus4.ovf}), 64'({e.c, e.o}));
            end
            got++;
         end
         acc = bus4.in_valid && bus4.in_ready;
         if (acc) begin
            q.push_back(model(bus4.op_a, bus4.op_b, bus4.op_sub, bus4.lane_mode, bus4.cin));
            sent++;
         end
         stall_prev = bus4.out_valid && !bus4.out_ready;
         held = {bus4.sum, bus4.cout, bus4.ovf};
         @(posedge clk); #1;
         if (acc) begin
            if (sent < 16) present(sent);
            else bus4.in_valid = 1'b0;
         end
      end
      chk("stream_count", 64'(got), 64'd16);
      chk("stream_leftover", 64'(q.size()), 64'd0);

      // Reset with beats in flight
      sweep_en = 1'b1;
      bus4.out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         present(n);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(bus4.out_valid), 64'd0);
      chk("midrst_sum", bus4.sum, 64'd0);
      chk("midrst_valid_m63", 64'(bus63.out_valid), 64'd0);
      bus4.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus4.out_ready = 1'b1;
      seen = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(posedge clk); #1;
         seen += int'(bus0.out_valid) + int'(bus4.out_valid) + int'(bus63.out_valid);
      end
      chk("postrst_idle", 64'(seen), 64'd0);
      send_single({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2'd2, 8'($urandom), "postrst", r);
      seen = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         seen += int'(bus0.out_valid) + int'(bus4.out_valid) + int'(bus63.out_valid);
         @(posedge clk); #1;
      end
      chk("postrst_alone", 64'(seen), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
